instr_fetch_unit: RTL and testbench

Instruction fetch stage placed directly upstream of the CONTROL decoder. It owns the program counter and drives a synchronous instruction memory with one-cycle read latency. It registers each fetched 16-bit word as `command_code` with a valid flag for CONTROL. It supports stall, branch redirect and a halt opcode.

---
 rtl/core_pkg.sv | 25 ++
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the fetch stage and the CONTROL decoder:
// instruction width, halt opcode, fetch FSM states and the opcode set.
package core_pkg;

   localparam int INSTR_WIDTH = 16;

   // An all-ones word stops the fetch stage instead of being forwarded.
   localparam logic [15:0] HALT_CODE = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

   // Opcode range shared with CONTROL: ADD is the first code, ADD-with-carry the last.
   localparam logic [15:0] OP_ADD = 16'h0001;
   localparam logic [15:0] OP_ADC = 16'h0010;

   // True when a word lies inside the opcode range CONTROL decodes.
   function automatic logic is_known_opcode(input logic [15:0] word);
      return (word >= OP_ADD) && (word <= OP_ADC);
   endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a one-cycle-latency
// instruction memory and presents each fetched word, registered, to CONTROL.
// Supports stall (with replay of the in-flight word), branch redirect and a
// halt opcode that parks the stage until reset.
module instr_fetch_unit #(
   parameter int ADDR_WIDTH  = 8,
   parameter int INSTR_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   stall,
   input  logic                   branch_valid,
   input  logic [ADDR_WIDTH-1:0]  branch_target,
   output logic                   imem_en,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic [INSTR_WIDTH-1:0] command_code,
   output logic                   command_valid,
   output logic [ADDR_WIDTH-1:0]  command_pc,
   output logic                   halted
);

   import core_pkg::*;

   localparam logic [ADDR_WIDTH-1:0]  PC_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0]  PC_ZERO  = {ADDR_WIDTH{1'b0}};
   localparam logic [INSTR_WIDTH-1:0] CODE_ZERO = {INSTR_WIDTH{1'b0}};
   localparam logic [INSTR_WIDTH-1:0] HALT_WORD = {INSTR_WIDTH{1'b1}};

   fetch_state_e            r_state;
   logic [ADDR_WIDTH-1:0]   r_pc;
   logic                    r_issued;
   logic [ADDR_WIDTH-1:0]   r_issued_addr;
   logic [INSTR_WIDTH-1:0]  r_code;
   logic                    r_valid;
   logic [ADDR_WIDTH-1:0]   r_cmd_pc;
   logic                    r_halted;

   logic                    w_halt_word;

   assign w_halt_word   = (imem_rdata == HALT_WORD);

   assign command_code  = r_code;
   assign command_valid = r_valid;
   assign command_pc    = r_cmd_pc;
   assign halted        = r_halted;

   // Read request: branch target wins, a stall suppresses the read, otherwise fetch the PC.
   always_comb begin
      imem_en   = 1'b0;
      imem_addr = r_pc;
      case (r_state)
         RUN: begin
            if (branch_valid) begin
               imem_en   = 1'b1;
               imem_addr = branch_target;
            end else if (stall) begin
               imem_en   = 1'b0;
               imem_addr = r_pc;
            end else begin
               imem_en   = 1'b1;
               imem_addr = r_pc;
            end
         end
         default: begin
            imem_en   = 1'b0;
            imem_addr = r_pc;
         end
      endcase
   end

   // PC, in-flight tracking, output registers and FSM; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_pc          <= PC_ZERO;
         r_issued      <= 1'b0;
         r_issued_addr <= PC_ZERO;
         r_code        <= CODE_ZERO;
         r_valid       <= 1'b0;
         r_cmd_pc      <= PC_ZERO;
         r_halted      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_issued <= 1'b0;
               if (start) begin
                  r_state <= RUN;
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               if (branch_valid) begin
                  // Redirect: the word arriving now belongs to the old path.
                  r_pc          <= branch_target + PC_ONE;
                  r_issued      <= 1'b1;
                  r_issued_addr <= branch_target;
                  r_valid       <= 1'b0;
               end else if (stall) begin
                  // Outputs freeze; an arriving word is dropped and fetched again later.
                  if (r_issued) begin
                     r_pc <= r_issued_addr;
                  end else begin
                     r_pc <= r_pc;
                  end
                  r_issued <= 1'b0;
               end else begin
                  r_pc          <= r_pc + PC_ONE;
                  r_issued      <= 1'b1;
                  r_issued_addr <= r_pc;
                  if (r_issued) begin
                     if (w_halt_word) begin
                        r_valid  <= 1'b0;
                        r_halted <= 1'b1;
                        r_issued <= 1'b0;
                        r_state  <= HALTED;
                     end else begin
                        r_code   <= imem_rdata;
                        r_cmd_pc <= r_issued_addr;
                        r_valid  <= 1'b1;
                     end
                  end else begin
                     r_valid <= 1'b0;
                  end
               end
            end
            HALTED: begin
               r_state  <= HALTED;
               r_issued <= 1'b0;
               r_valid  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a transaction-level reference model
// logs which address is issued each cycle and derives the word presented two
// cycles later; a monitor pops expectations and compares every cycle.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        stall;
   logic        branch_valid;
   logic [7:0]  branch_target;
   logic        imem_en;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic [15:0] command_code;
   logic        command_valid;
   logic [7:0]  command_pc;
   logic        halted;

   logic [15:0] rom [0:255];

   typedef struct {
      logic        valid;
      logic [15:0] code;
      logic [7:0]  pc;
      logic        halted;
      logic        chk_all;
      logic        en;
      logic [7:0]  addr;
      logic        chk_addr;
   } exp_t;

   exp_t sb[$];
   int   vectors;
   int   miscompares;

   // reference model state
   int          m_state;   // 0 idle, 1 run, 2 halted
   logic [7:0]  m_next;
   logic        m_valid;
   logic [15:0] m_code;
   logic [7:0]  m_pc;
   logic        m_halted;
   logic        m_fresh_reset;
   int          issue_at [0:8191];
   int          cyc_n;

   instr_fetch_unit #(.ADDR_WIDTH(8), .INSTR_WIDTH(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .stall         (stall),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .imem_en       (imem_en),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .command_code  (command_code),
      .command_valid (command_valid),
      .command_pc    (command_pc),
      .halted        (halted)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // synchronous ROM, one-cycle read latency
   initial imem_rdata = 16'd0;
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= rom[imem_addr];
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // monitor: compare DUT against the oldest expectation every cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("command_valid", {15'd0, command_valid}, {15'd0, e.valid});
            chk("halted", {15'd0, halted}, {15'd0, e.halted});
            chk("imem_en", {15'd0, imem_en}, {15'd0, e.en});
            if (e.valid || e.chk_all) begin
               chk("command_code", command_code, e.code);
               chk("command_pc", {8'd0, command_pc}, {8'd0, e.pc});
            end
            if (e.chk_addr) chk("imem_addr", {8'd0, imem_addr}, {8'd0, e.addr});
         end
      end
   end

   // one clock of stimulus: record expectation, then advance the model
   task automatic cyc(input logic rs, input logic st, input logic sl,
                      input logic bv, input logic [7:0] tg);
      exp_t e;
      int   arr;
      @(posedge clk);
      #2;
      rst_n = rs; start = st; stall = sl; branch_valid = bv; branch_target = tg;

      e.valid = m_valid; e.code = m_code; e.pc = m_pc; e.halted = m_halted;
      e.chk_all = m_fresh_reset;
      e.en = 1'b0; e.addr = m_next; e.chk_addr = (m_state == 0);
      if (m_state == 1) begin
         if (bv) begin
            e.en = 1'b1; e.addr = tg; e.chk_addr = 1'b1;
         end else if (!sl) begin
            e.en = 1'b1; e.addr = m_next; e.chk_addr = 1'b1;
         end
      end
      sb.push_back(e);

      arr = (cyc_n > 0) ? issue_at[cyc_n-1] : -1;
      issue_at[cyc_n] = -1;
      m_fresh_reset = 1'b0;
      if (!rs) begin
         m_state = 0; m_next = 8'd0; m_valid = 1'b0; m_code = 16'd0;
         m_pc = 8'd0; m_halted = 1'b0; m_fresh_reset = 1'b1;
      end else if (m_state == 0) begin
         if (st) m_state = 1;
      end else if (m_state == 1) begin
         if (bv) begin
            issue_at[cyc_n] = int'(tg);
            m_next  = tg + 8'd1;
            m_valid = 1'b0;
         end else if (sl) begin
            if (arr >= 0) m_next = arr[7:0];
         end else begin
            issue_at[cyc_n] = int'(m_next);
            m_next = m_next + 8'd1;
            if (arr >= 0) begin
               if (rom[arr] == 16'hFFFF) begin
                  m_valid = 1'b0; m_halted = 1'b1; m_state = 2;
               end else begin
                  m_valid = 1'b1; m_code = rom[arr]; m_pc = arr[7:0];
               end
            end else begin
               m_valid = 1'b0;
            end
         end
      end
      cyc_n++;
   endtask

   // stimulus
   initial begin
      vectors = 0; miscompares = 0;
      rst_n = 1'b0; start = 1'b0; stall = 1'b0; branch_valid = 1'b0; branch_target = 8'd0;
      m_state = 0; m_next = 8'd0; m_valid = 1'b0; m_code = 16'd0; m_pc = 8'd0;
      m_halted = 1'b0; m_fresh_reset = 1'b1; cyc_n = 0;

      for (int i = 0; i < 256; i++) rom[i] = 16'($urandom_range(0, 16'hFFFE));
      rom[0] = 16'h0001; rom[1] = 16'h0002; rom[2] = 16'h0003; rom[3] = 16'h0004;
      rom[8'h40] = 16'h000C;

      // reset, start, straight-line fetch of 0001..0004 and beyond
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
      repeat (6) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

      // restart so 0002 is in flight when the 3-cycle stall hits
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
      repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
      repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

      // branch to 0x40, then stall and branch together
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h40);
      repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h40);
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

      // PC wrap across 0xFF
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'hFD);
      repeat (6) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

      // reset asserted mid-stall
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h10);
      repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

      // randomized traffic with occasional resets and restarts
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 300; i++) begin
         cyc(logic'($urandom_range(0, 99) != 0),
             logic'($urandom_range(0, 1)),
             logic'($urandom_range(0, 99) < 25),
             logic'($urandom_range(0, 99) < 12),
             8'($urandom_range(0, 255)));
      end

      // halt: five ADDs then FFFF; later branch/stall/start are ignored
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 5; i++) rom[i] = 16'h0001;
      rom[5] = 16'hFFFF;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
      repeat (9) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h40);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

      @(negedge clk);
      @(negedge clk);
      #1;
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
